// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_NREGS  = 32;

    // Register 0 is hardwired to zero and never marked busy.
    localparam int REG_ZERO = 0;

    // Width needed to hold an index in [0, n-1]; at least one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register pending-producer bits with a registered population count.
// Latency: set/clear take effect on the edge they are sampled; outputs are registered.
// Backpressure: none; one set and one clear are accepted every cycle, set wins on a shared index.
module regfile_busy_tracker
    import regfile_pkg::*;
#(
    parameter int NREGS = DEFAULT_NREGS,
    localparam int AW = idx_width(NREGS),
    localparam int CW = idx_width(NREGS + 1)
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             set_vld_i,
    input  logic [AW-1:0]    set_idx_i,
    input  logic             clr_vld_i,
    input  logic [AW-1:0]    clr_idx_i,
    output logic [NREGS-1:0] busy_o,
    output logic [CW-1:0]    count_o
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    count_q, count_d;
    logic             set_eff, clr_eff, inc, dec;

    // Next busy vector and count: clear first so a same-index set overrides it.
    always_comb begin
        set_eff = set_vld_i && (set_idx_i != AW'(REG_ZERO));
        clr_eff = clr_vld_i && (clr_idx_i != AW'(REG_ZERO));
        // Count only real state changes; a clear masked by a same-index set is no change.
        inc = set_eff && !busy_q[set_idx_i];
        dec = clr_eff && busy_q[clr_idx_i] && !(set_eff && (set_idx_i == clr_idx_i));
        busy_d = busy_q;
        if (clr_eff) busy_d[clr_idx_i] = 1'b0;
        if (set_eff) busy_d[set_idx_i] = 1'b1;
        count_d = count_q + CW'(inc) - CW'(dec);
    end

    // Busy state register, cleared asynchronously.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o  = busy_q;
    assign count_o = count_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file, 2 async read ports, 1 sync write port, busy scoreboard for multicycle ops.
// Latency: reads 0 cycles; writes visible next cycle (same cycle if REGFILE_SB_BYPASS_EN is defined).
// Backpressure: none; a write and a busy-set are accepted every cycle.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int NREGS  = DEFAULT_NREGS,
    localparam int AW = idx_width(NREGS),
    localparam int CW = idx_width(NREGS + 1)
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [AW-1:0]     ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [AW-1:0]     ctrl_readRegA,
    input  logic [AW-1:0]     ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    input  logic              ctrl_busySet,
    input  logic [AW-1:0]     ctrl_busyReg,
    output logic              busyA,
    output logic              busyB,
    output logic [CW-1:0]     busy_count,
    input  logic [AW-1:0]     ctrl_dbgReg,
    output logic [DATA_W-1:0] data_dbgReg
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [NREGS-1:0]  busy_vec;
    logic              wr_hit;

    assign wr_hit = ctrl_writeEnable && (ctrl_writeReg != AW'(REG_ZERO));

    // A writeback retires the pending producer of its destination.
    regfile_busy_tracker #(
        .NREGS (NREGS)
    ) u_busy (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .set_vld_i  (ctrl_busySet),
        .set_idx_i  (ctrl_busyReg),
        .clr_vld_i  (ctrl_writeEnable),
        .clr_idx_i  (ctrl_writeReg),
        .busy_o     (busy_vec),
        .count_o    (busy_count)
    );

    // Next storage contents; register 0 is never written so it stays zero.
    always_comb begin
        regs_d = regs_q;
        if (wr_hit) regs_d[ctrl_writeReg] = data_writeReg;
    end

    // Storage array, cleared asynchronously.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes; optional same-cycle forwarding of the write port.
    always_comb begin
        data_readRegA = regs_q[ctrl_readRegA];
        data_readRegB = regs_q[ctrl_readRegB];
        busyA         = busy_vec[ctrl_readRegA];
        busyB         = busy_vec[ctrl_readRegB];
`ifdef REGFILE_SB_BYPASS_EN
        // Forwarded data is final unless a new producer claims the same register now.
        if (wr_hit && (ctrl_writeReg == ctrl_readRegA)) begin
            data_readRegA = data_writeReg;
            busyA         = ctrl_busySet && (ctrl_busyReg == ctrl_readRegA);
        end
        if (wr_hit && (ctrl_writeReg == ctrl_readRegB)) begin
            data_readRegB = data_writeReg;
            busyB         = ctrl_busySet && (ctrl_busyReg == ctrl_readRegB);
        end
`endif
    end

    // Debug probe always shows the stored value.
    assign data_dbgReg = regs_q[ctrl_dbgReg];

endmodule
